// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter: single-port framebuffer SRAM arbiter.
// The feeder's reads always win the port. Host pixel writes are queued in a
// small FIFO and drained into SRAM on cycles the feeder leaves free.
// Optional full-screen clear engine enabled by defining FB_CLEAR_EN.
module fb_mem_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int FB_ROWS    = 48
) (
    input  logic        clk_25,
    input  logic        rst,
    input  logic        mem_read,
    input  logic [8:0]  rd_addr,
    input  logic [2:0]  rd_pix_sel,
    output logic [3:0]  rd_pixel,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [5:0]  wr_x,
    input  logic [5:0]  wr_y,
    input  logic [3:0]  wr_pix,
    output logic        wr_drop,
    input  logic        clr_req,
    input  logic [3:0]  clr_colour,
    output logic        clr_busy,
    output logic [8:0]  sram_addr,
    output logic        sram_we,
    output logic [7:0]  sram_wmask,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [6:0]    ROWS_C   = 7'(FB_ROWS);
    localparam logic [8:0]    CLR_LAST = 9'(FB_ROWS * 8 - 1);

`ifdef FB_CLEAR_EN
    typedef enum logic [1:0] {S_IDLE, S_CLR_WAIT, S_CLEAR} state_t;
`else
    typedef enum logic [0:0] {S_IDLE} state_t;
`endif

    // FIFO entry packing: {y[5:0], x[5:0], pix[3:0]}
    logic [15:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          drop_reg;
    state_t        state_reg, state_next;

    logic [15:0] head;
    logic        accept, in_range, push, pop, drain_ok;

    assign head     = fifo_mem[rd_ptr_reg];
    assign wr_ready = !rst && (count_reg < DEPTH_C);
    assign accept   = wr_valid && wr_ready;
    assign in_range = {1'b0, wr_y} < ROWS_C;
    assign push     = accept && in_range;
    assign pop      = drain_ok && !mem_read && (count_reg != '0) && !rst;
    assign wr_drop  = drop_reg;
    assign rd_pixel = sram_rdata[{rd_pix_sel, 2'b00} +: 4];

`ifdef FB_CLEAR_EN
    logic [8:0] clr_addr_reg, clr_addr_next;
    logic [3:0] colour_reg, colour_next;

    assign drain_ok = (state_reg == S_IDLE) || (state_reg == S_CLR_WAIT);
    assign clr_busy = (state_reg != S_IDLE);
`else
    logic unused_clr;

    assign drain_ok   = (state_reg == S_IDLE);
    assign clr_busy   = 1'b0;
    assign unused_clr = &{1'b0, clr_req, clr_colour};
`endif

    // FIFO storage; data needs no reset since count gates its use
    always_ff @(posedge clk_25) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {wr_y, wr_x, wr_pix};
        end
    end

    // FIFO pointers, occupancy and drop pulse
    always_ff @(posedge clk_25) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            drop_reg   <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_reg + CW'(push) - CW'(pop);
            drop_reg  <= accept && !in_range;
        end
    end

    // SRAM port mux: feeder read, then FIFO drain, then clear write
    always_comb begin
        sram_addr  = rd_addr;
        sram_we    = 1'b0;
        sram_wmask = 8'h00;
        sram_wdata = 32'h0;
        if (!mem_read && !rst) begin
            if (pop) begin
                sram_addr  = {head[15:10], head[9:7]};
                sram_we    = 1'b1;
                sram_wmask = 8'h01 << head[6:4];
                sram_wdata = {8{head[3:0]}};
            end
`ifdef FB_CLEAR_EN
            else if (state_reg == S_CLEAR) begin
                sram_addr  = clr_addr_reg;
                sram_we    = 1'b1;
                sram_wmask = 8'hFF;
                sram_wdata = {8{colour_reg}};
            end
`endif
        end
    end

`ifdef FB_CLEAR_EN
    // State, clear address and clear colour registers
    always_ff @(posedge clk_25) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            clr_addr_reg <= '0;
            colour_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
            colour_reg   <= colour_next;
        end
    end

    // Next-state: wait for the FIFO to empty, then sweep the whole screen
    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        colour_next   = colour_reg;
        case (state_reg)
            S_IDLE: begin
                if (clr_req) begin
                    state_next  = S_CLR_WAIT;
                    colour_next = clr_colour;
                end
            end
            S_CLR_WAIT: begin
                if (count_reg == '0 && !push) begin
                    state_next    = S_CLEAR;
                    clr_addr_next = '0;
                end
            end
            S_CLEAR: begin
                if (!mem_read) begin
                    if (clr_addr_reg == CLR_LAST) begin
                        state_next    = S_IDLE;
                        clr_addr_next = '0;
                    end else begin
                        clr_addr_next = clr_addr_reg + 9'd1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end
`else
    // State register; only the idle state exists without the clear engine
    always_ff @(posedge clk_25) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    // Next-state: always idle
    always_comb begin
        state_next = S_IDLE;
    end
`endif

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Testbench for fb_mem_arbiter: directed steps, SRAM write scoreboard.
module tb_fb_mem_arbiter;

    logic        clk_25 = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic [8:0]  rd_addr = '0;
    logic [2:0]  rd_pix_sel = '0;
    logic [3:0]  rd_pixel;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [5:0]  wr_x = '0, wr_y = '0;
    logic [3:0]  wr_pix = '0;
    logic        wr_drop;
    logic        clr_req = 1'b0;
    logic [3:0]  clr_colour = '0;
    logic        clr_busy;
    logic [8:0]  sram_addr;
    logic        sram_we;
    logic [7:0]  sram_wmask;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = '0;

    typedef struct {
        logic [8:0]  addr;
        logic [7:0]  mask;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;
    int  n_assert = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b1;
    bit  done;

    fb_mem_arbiter dut (
        .clk_25(clk_25), .rst(rst), .mem_read(mem_read), .rd_addr(rd_addr),
        .rd_pix_sel(rd_pix_sel), .rd_pixel(rd_pixel), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_pix(wr_pix),
        .wr_drop(wr_drop), .clr_req(clr_req), .clr_colour(clr_colour),
        .clr_busy(clr_busy), .sram_addr(sram_addr), .sram_we(sram_we),
        .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk_25 = ~clk_25;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_25);
        #1;
    endtask

    task automatic push_exp(input logic [8:0] a, input logic [7:0] m, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.mask = m;
        e.data = d;
        sb.push_back(e);
    endtask

    // Drive one host write; expectation from the address/nibble mapping
    task automatic do_write(input logic [5:0] x, input logic [5:0] y, input logic [3:0] p);
        wr_x = x;
        wr_y = y;
        wr_pix = p;
        wr_valid = 1'b1;
        if (y < 6'd48) push_exp({y, x[5:3]}, 8'h01 << x[2:0], {8{p}});
        step();
        wr_valid = 1'b0;
    endtask

    // Every SRAM write is matched in order against the scoreboard
    always @(negedge clk_25) begin
        if (mon_en && sram_we) begin
            check("wr_during_read", 32'(mem_read), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_wr", 32'(sram_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                $display("sram write addr=%h mask=%h data=%h", sram_addr, sram_wmask, sram_wdata);
                check("wr_addr", 32'(sram_addr), 32'(mon_e.addr));
                check("wr_mask", 32'(sram_wmask), 32'(mon_e.mask));
                check("wr_data", sram_wdata, mon_e.data);
            end
        end
    end

    initial begin
        // Reset state
        step();
        step();
        @(negedge clk_25);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_we", 32'(sram_we), 32'd0);
        check("rst_drop", 32'(wr_drop), 32'd0);
        check("rst_busy", 32'(clr_busy), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk_25);
        check("post_rst_ready", 32'(wr_ready), 32'd1);

        // Single write, one cycle latency
        step();
        do_write(6'd13, 6'd2, 4'd7);
        @(negedge clk_25);
        check("lat1_we", 32'(sram_we), 32'd1);
        check("lat1_addr", 32'(sram_addr), 32'h011);
        step();
        @(negedge clk_25);
        check("lat1_idle", 32'(sram_we), 32'd0);

        // Fill FIFO while feeder holds the port
        step();
        mem_read = 1'b1;
        rd_addr = 9'h040;
        do_write(6'd1, 6'd0, 4'h1);
        do_write(6'd10, 6'd5, 4'h2);
        do_write(6'd63, 6'd47, 4'hF);
        do_write(6'd0, 6'd20, 4'h4);
        @(negedge clk_25);
        check("full_ready", 32'(wr_ready), 32'd0);
        check("full_no_we", 32'(sram_we), 32'd0);
        step();
        mem_read = 1'b0;
        @(negedge clk_25);
        check("drain1_we", 32'(sram_we), 32'd1);
        check("drain1_ready", 32'(wr_ready), 32'd0);
        step();
        @(negedge clk_25);
        check("drain2_we", 32'(sram_we), 32'd1);
        check("drain2_ready", 32'(wr_ready), 32'd1);
        step();
        @(negedge clk_25);
        check("drain3_we", 32'(sram_we), 32'd1);
        step();
        @(negedge clk_25);
        check("drain4_we", 32'(sram_we), 32'd1);
        step();
        @(negedge clk_25);
        check("drain_done", 32'(sram_we), 32'd0);

        // Out-of-range row: accepted then dropped
        step();
        do_write(6'd5, 6'd50, 4'h9);
        @(negedge clk_25);
        check("drop_pulse", 32'(wr_drop), 32'd1);
        check("drop_no_we", 32'(sram_we), 32'd0);
        step();
        @(negedge clk_25);
        check("drop_end", 32'(wr_drop), 32'd0);
        check("drop_no_we2", 32'(sram_we), 32'd0);

        // Feeder read has priority over a pending write
        step();
        sram_rdata = 32'hFEDCBA98;
        mem_read = 1'b1;
        rd_addr = 9'h0AB;
        rd_pix_sel = 3'd5;
        do_write(6'd1, 6'd3, 4'hC);
        @(negedge clk_25);
        check("rd_pix5", 32'(rd_pixel), 32'hD);
        check("rd_no_we", 32'(sram_we), 32'd0);
        check("rd_addr", 32'(sram_addr), 32'h0AB);
        step();
        rd_pix_sel = 3'd7;
        @(negedge clk_25);
        check("rd_pix7", 32'(rd_pixel), 32'hF);
        step();
        rd_pix_sel = 3'd0;
        @(negedge clk_25);
        check("rd_pix0", 32'(rd_pixel), 32'h8);
        step();
        mem_read = 1'b0;
        @(negedge clk_25);
        check("rd_then_drain", 32'(sram_we), 32'd1);
        step();

`ifdef FB_CLEAR_EN
        // Clear after two queued writes, with periodic feeder reads
        mem_read = 1'b1;
        do_write(6'd8, 6'd1, 4'h2);
        do_write(6'd0, 6'd0, 4'h4);
        mem_read = 1'b0;
        clr_req = 1'b1;
        clr_colour = 4'd3;
        for (int a = 0; a < 384; a++) push_exp(9'(a), 8'hFF, 32'h33333333);
        step();
        clr_req = 1'b0;
        clr_colour = 4'd0;
        done = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            mem_read = (cyc % 10 == 9);
            clr_req = (cyc == 50);
            clr_colour = (cyc == 50) ? 4'd9 : 4'd0;
            @(negedge clk_25);
            if (!clr_busy) begin
                done = 1'b1;
                break;
            end
            step();
        end
        mem_read = 1'b0;
        clr_req = 1'b0;
        check("clear_finished", 32'(done), 32'd1);
        check("clear_all_written", 32'(sb.size()), 32'd0);
        step();

        // Reset in the middle of a clear
        mon_en = 1'b0;
        clr_req = 1'b1;
        clr_colour = 4'd5;
        step();
        clr_req = 1'b0;
        done = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk_25);
            if (sram_we && sram_addr == 9'd100) begin
                done = 1'b1;
                break;
            end
            step();
        end
        check("reach_addr100", 32'(done), 32'd1);
        rst = 1'b1;
        step();
        @(negedge clk_25);
        check("midrst_busy", 32'(clr_busy), 32'd0);
        check("midrst_we", 32'(sram_we), 32'd0);
        check("midrst_ready", 32'(wr_ready), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk_25);
        check("midrst_count0", 32'(wr_ready), 32'd1);
        check("midrst_idle", 32'(clr_busy), 32'd0);
        step();
        mon_en = 1'b1;
        for (int a = 0; a < 384; a++) push_exp(9'(a), 8'hFF, 32'h66666666);
        clr_req = 1'b1;
        clr_colour = 4'd6;
        step();
        clr_req = 1'b0;
        done = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk_25);
            if (!clr_busy) begin
                done = 1'b1;
                break;
            end
            step();
        end
        check("reclear_finished", 32'(done), 32'd1);
        step();
`else
        // Clear engine absent: request is ignored
        clr_req = 1'b1;
        clr_colour = 4'd3;
        step();
        clr_req = 1'b0;
        @(negedge clk_25);
        check("noclr_busy", 32'(clr_busy), 32'd0);
        check("noclr_we", 32'(sram_we), 32'd0);
        step();
        @(negedge clk_25);
        check("noclr_we2", 32'(sram_we), 32'd0);
        step();
`endif

        @(negedge clk_25);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
